// File: rtl/qed_dup_scheduler.sv
// qed_dup_scheduler: alternates original fetch and duplicate replay for the QED instruction queue
// Ports:
//   clk                  clock, all state on posedge
//   rst                  asynchronous active-low reset
//   qed_ena              enable QED rounds
//   IF_stall             fetch stall, same signal the queue sees
//   ifu_qed_instruction  fetched instruction, same signal the queue sees
//   exec_dup             registered, 1 = replay duplicates from the queue
//   qed_check            registered one-cycle strobe at the end of a drained round
//   occupancy            mirrored queue fill level
//   round_cnt            completed rounds, wraps
//   busy                 1 when not idle
module qed_dup_scheduler #(
    parameter int DEPTH        = 128,
    parameter int OCC_W        = 8,
    parameter int ORIG_BUDGET  = 32,
    parameter int IDLE_LIMIT   = 16,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             qed_ena,
    input  logic             IF_stall,
    input  logic [31:0]      ifu_qed_instruction,
    output logic             exec_dup,
    output logic             qed_check,
    output logic [OCC_W-1:0] occupancy,
    output logic [15:0]      round_cnt,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ORIG, DUP, DRAIN} state_t;
    localparam logic [OCC_W-1:0] FULL   = OCC_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] BUDGET = OCC_W'(ORIG_BUDGET);
    localparam logic [OCC_W-1:0] ILIM   = OCC_W'(IDLE_LIMIT);
    localparam logic [OCC_W-1:0] DLIM   = OCC_W'(DRAIN_CYCLES);
    localparam logic [OCC_W-1:0] ONE    = OCC_W'(1);
    state_t state, state_nx;
    logic [OCC_W-1:0] orig_cnt, idle_cnt, drain_cnt;
    logic [OCC_W-1:0] occ_nx, orig_nx, idle_nx, drain_nx;
    logic is_nop, ins, del, clr, drain_done;
    logic exec_dup_nx, qed_check_nx, busy_nx;
    logic unused_instr_hi;
    assign unused_instr_hi = ^ifu_qed_instruction[31:7];
    // Insert/delete mirror the queue's own conditions so no handshake is needed.
    always_comb begin
        is_nop     = ifu_qed_instruction[6:0] == 7'h7F;
        ins        = (state == ORIG) && !IF_stall && !is_nop && (occupancy < FULL);
        del        = (state == DUP) && !IF_stall && (occupancy != '0);
        occ_nx     = ins ? occupancy + ONE : del ? occupancy - ONE : occupancy;
        orig_nx    = ins ? orig_cnt + ONE : orig_cnt;
        idle_nx    = ins ? '0 : (idle_cnt >= ILIM) ? ILIM : idle_cnt + ONE;
        drain_nx   = IF_stall ? drain_cnt : drain_cnt + ONE;
        drain_done = (state == DRAIN) && (drain_nx >= DLIM);
    end
    // Next-state: ORIG decisions use post-insert counts of this cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = qed_ena ? ORIG : IDLE;
            ORIG: begin
                if (orig_nx >= BUDGET || occ_nx >= FULL ||
                    (idle_nx >= ILIM && occ_nx != '0) || (!qed_ena && occ_nx != '0))
                    state_nx = DUP;
                else if (!qed_ena)
                    state_nx = IDLE;
            end
            DUP:   state_nx = (occ_nx == '0) ? DRAIN : DUP;
            DRAIN: state_nx = drain_done ? (qed_ena ? ORIG : IDLE) : DRAIN;
        endcase
    end
    // Outputs are decoded from the next state and registered, so they change with the state.
    always_comb begin
        exec_dup_nx  = (state_nx == DUP) || (state_nx == DRAIN);
        qed_check_nx = drain_done;
        busy_nx      = state_nx != IDLE;
        clr          = (state_nx == ORIG) && (state != ORIG);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            occupancy <= '0;
            orig_cnt  <= '0;
            idle_cnt  <= '0;
            drain_cnt <= '0;
            round_cnt <= '0;
            exec_dup  <= 1'b0;
            qed_check <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            occupancy <= occ_nx;
            orig_cnt  <= clr ? '0 : (state == ORIG) ? orig_nx : orig_cnt;
            idle_cnt  <= clr ? '0 : (state == ORIG) ? idle_nx : idle_cnt;
            drain_cnt <= (state == DRAIN) ? drain_nx : '0;
            round_cnt <= drain_done ? round_cnt + 16'd1 : round_cnt;
            exec_dup  <= exec_dup_nx;
            qed_check <= qed_check_nx;
            busy      <= busy_nx;
        end
    end
endmodule

// File: tb/tb_qed_dup_scheduler.sv
// tb_qed_dup_scheduler: directed checks of round sequencing, occupancy mirroring and reset
module tb_qed_dup_scheduler;
    localparam logic [31:0] NOP = 32'h0000007F;
    localparam logic [31:0] OP  = 32'h00000013;
    logic clk = 1'b0, rst = 1'b0, ena = 1'b0, ena2 = 1'b0, stall = 1'b0;
    logic [31:0] instr = NOP;
    logic exec_dup, qed_check, busy, exec_dup2, qed_check2, busy2;
    logic [7:0] occupancy, occ2;
    logic [15:0] round_cnt, rc2;
    int n = 0, fails = 0;
    always #5 clk = ~clk;
    qed_dup_scheduler u1 (
        .clk(clk), .rst(rst), .qed_ena(ena), .IF_stall(stall), .ifu_qed_instruction(instr),
        .exec_dup(exec_dup), .qed_check(qed_check), .occupancy(occupancy),
        .round_cnt(round_cnt), .busy(busy)
    );
    qed_dup_scheduler #(.ORIG_BUDGET(127)) u2 (
        .clk(clk), .rst(rst), .qed_ena(ena2), .IF_stall(stall), .ifu_qed_instruction(instr),
        .exec_dup(exec_dup2), .qed_check(qed_check2), .occupancy(occ2),
        .round_cnt(rc2), .busy(busy2)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        #3;
        chk("rst_exec_dup", exec_dup, 0);
        chk("rst_qed_check", qed_check, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_round", round_cnt, 0);
        chk("rst_busy", busy, 0);
        step(); step(); rst = 1'b1;
        // budget round
        ena = 1'b1; instr = OP; step();
        chk("orig_busy", busy, 1);
        chk("orig_exec_dup", exec_dup, 0);
        repeat (31) step();
        chk("occ31", occupancy, 31);
        chk("pre_budget_exec_dup", exec_dup, 0);
        step();
        chk("budget_exec_dup", exec_dup, 1);
        chk("occ32", occupancy, 32);
        instr = NOP; repeat (31) step();
        chk("dup_occ1", occupancy, 1);
        chk("dup_exec_dup", exec_dup, 1);
        step();
        chk("drain_occ0", occupancy, 0);
        chk("drain_exec_dup", exec_dup, 1);
        repeat (4) step();
        chk("drain_no_check", qed_check, 0);
        step();
        chk("r1_check", qed_check, 1);
        chk("r1_round", round_cnt, 1);
        chk("r1_exec_dup", exec_dup, 0);
        chk("r1_busy", busy, 1);
        step();
        chk("r1_check_one_cycle", qed_check, 0);
        // idle run with empty queue stays in ORIG
        for (int k = 0; k < 20; k++) begin stall = k[0]; step(); end
        stall = 1'b0;
        chk("empty_idle_exec_dup", exec_dup, 0);
        chk("empty_idle_occ", occupancy, 0);
        chk("empty_idle_busy", busy, 1);
        // idle timeout round
        instr = OP; repeat (3) step();
        chk("idle_occ3", occupancy, 3);
        instr = NOP;
        for (int k = 1; k <= 15; k++) begin stall = k[0]; step(); end
        stall = 1'b0;
        chk("idle15_exec_dup", exec_dup, 0);
        step();
        chk("idle16_exec_dup", exec_dup, 1);
        chk("idle16_occ", occupancy, 3);
        repeat (2) step();
        chk("idle_dup_occ1", occupancy, 1);
        step();
        chk("idle_dup_occ0", occupancy, 0);
        repeat (5) step();
        chk("r2_check", qed_check, 1);
        chk("r2_round", round_cnt, 2);
        chk("r2_exec_dup", exec_dup, 0);
        // qed_ena drop mid-DUP
        instr = OP; repeat (10) step();
        chk("ena_occ10", occupancy, 10);
        instr = NOP; repeat (16) step();
        chk("ena_dup_exec_dup", exec_dup, 1);
        chk("ena_dup_occ10", occupancy, 10);
        ena = 1'b0; repeat (9) step();
        chk("ena_off_occ1", occupancy, 1);
        chk("ena_off_exec_dup", exec_dup, 1);
        chk("ena_off_busy", busy, 1);
        step();
        chk("ena_off_occ0", occupancy, 0);
        repeat (4) step();
        chk("ena_off_no_check", qed_check, 0);
        step();
        chk("r3_check", qed_check, 1);
        chk("r3_round", round_cnt, 3);
        chk("r3_busy", busy, 0);
        chk("r3_exec_dup", exec_dup, 0);
        // near-full with budget 127 and alternating stalls
        ena2 = 1'b1; instr = OP; step();
        chk("full_busy", busy2, 1);
        for (int i = 0; i < 254; i++) begin
            stall = i[0];
            step();
            if (i == 251) begin
                chk("full_occ126", occ2, 126);
                chk("full_pre_exec_dup", exec_dup2, 0);
            end
        end
        chk("full_occ127", occ2, 127);
        chk("full_exec_dup", exec_dup2, 1);
        stall = 1'b1; step();
        chk("full_stall_occ127", occ2, 127);
        chk("u1_idle_occ", occupancy, 0);
        stall = 1'b0; ena2 = 1'b0; repeat (127) step();
        chk("full_drain_occ0", occ2, 0);
        chk("full_drain_exec_dup", exec_dup2, 1);
        repeat (5) step();
        chk("full_check", qed_check2, 1);
        chk("full_round", rc2, 1);
        chk("full_busy_end", busy2, 0);
        // async reset mid-DUP
        ena = 1'b1; step();
        instr = OP; repeat (7) step();
        instr = NOP; repeat (16) step();
        chk("ar_exec_dup", exec_dup, 1);
        chk("ar_occ7", occupancy, 7);
        stall = 1'b1; repeat (2) step();
        chk("ar_stall_occ7", occupancy, 7);
        #2 rst = 1'b0;
        #1;
        chk("ar_exec_dup0", exec_dup, 0);
        chk("ar_check0", qed_check, 0);
        chk("ar_occ0", occupancy, 0);
        chk("ar_round0", round_cnt, 0);
        chk("ar_busy0", busy, 0);
        step(); rst = 1'b1; stall = 1'b0;
        repeat (8) step();
        chk("ar_after_check", qed_check, 0);
        chk("ar_after_round", round_cnt, 0);
        chk("ar_after_exec_dup", exec_dup, 0);
        // round counter wrap
        force u1.round_cnt = 16'hFFFF;
        #1 release u1.round_cnt;
        chk("wrap_preload", round_cnt, 16'hFFFF);
        instr = OP; step();
        instr = NOP; repeat (16) step();
        chk("wrap_exec_dup", exec_dup, 1);
        step();
        repeat (5) step();
        chk("wrap_check", qed_check, 1);
        chk("wrap_round0", round_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
